// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard unit: Tuse/Tnew decode, writer scoreboard,
// stall, forward selects and the HI/LO busy interlock.
//
// Ports:
//   clk, reset             clock, sync active-high reset
//   instr_d                instruction in D
//   stall                  freeze PC and IF/ID, bubble into E
//   rs_d, rt_d             source register fields of instr_d
//   fwd_rs_sel, fwd_rt_sel 0 = regfile, k+1 = scoreboard entry k
//   md_busy                HI/LO unit busy
//   dst_e, tnew_e          destination and Tnew of entry 0 (E)
// Optional feature: define MD_INTERLOCK_EN to build the HI/LO
// busy counter; without it md_busy is 0.
module decode_hazard_unit #(
  parameter  int DEPTH       = 3,
  parameter  int MULT_CYCLES = 5,
  parameter  int DIV_CYCLES  = 10,
  localparam int FW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_d,
  output logic          stall,
  output logic [4:0]    rs_d,
  output logic [4:0]    rt_d,
  output logic [FW-1:0] fwd_rs_sel,
  output logic [FW-1:0] fwd_rt_sel,
  output logic          md_busy,
  output logic [4:0]    dst_e,
  output logic [1:0]    tnew_e
);

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic [1:0] tnew;
  } sb_t;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rd;

  assign op   = instr_d[31:26];
  assign fn   = instr_d[5:0];
  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];
  assign rd   = instr_d[15:11];

  logic rtype;
  logic c_alu, c_shi, c_imm, c_ld, c_st;
  logic c_br2, c_br1, c_jr, c_jalr, c_jal;
  logic c_md, c_mf, c_mt;

  assign rtype = (op == 6'b000000);

  always_comb begin
    c_alu  = rtype && (fn inside {
               6'b100000, 6'b100001, 6'b100010,
               6'b100011, 6'b101010, 6'b101011,
               6'b100100, 6'b100101, 6'b100111,
               6'b100110, 6'b000100, 6'b000110,
               6'b000111});
    c_shi  = rtype && (fn inside {
               6'b000000, 6'b000010, 6'b000011});
    c_jr   = rtype && (fn == 6'b001000);
    c_jalr = rtype && (fn == 6'b001001);
    c_md   = rtype && (fn inside {
               6'b011000, 6'b011001,
               6'b011010, 6'b011011});
    c_mf   = rtype && (fn inside {
               6'b010000, 6'b010010});
    c_mt   = rtype && (fn inside {
               6'b010001, 6'b010011});
    c_imm  = op inside {
               6'b001000, 6'b001001, 6'b001100,
               6'b001101, 6'b001110, 6'b001010,
               6'b001011, 6'b001111};
    c_ld   = op inside {
               6'b100011, 6'b100001, 6'b100101,
               6'b100000, 6'b100100};
    c_st   = op inside {
               6'b101011, 6'b101001, 6'b101000};
    c_br2  = op inside {6'b000100, 6'b000101};
    c_br1  = (op inside {6'b000110, 6'b000111})
          || ((op == 6'b000001)
           && (rt_d inside {5'b00000, 5'b00001}));
    c_jal  = (op == 6'b000011);
  end

  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [4:0] dst_dec;
  logic [1:0] tnew_dec;

  always_comb begin
    tuse_rs  = 2'd3;
    tuse_rt  = 2'd3;
    dst_dec  = 5'd0;
    tnew_dec = 2'd0;
    unique case (1'b1)
      c_alu: begin
        tuse_rs  = 2'd1;
        tuse_rt  = 2'd1;
        dst_dec  = rd;
        tnew_dec = 2'd1;
      end
      c_shi: begin
        tuse_rt  = 2'd1;
        dst_dec  = rd;
        tnew_dec = 2'd1;
      end
      c_imm: begin
        tuse_rs  = 2'd1;
        dst_dec  = rt_d;
        tnew_dec = 2'd1;
      end
      c_ld: begin
        tuse_rs  = 2'd1;
        dst_dec  = rt_d;
        tnew_dec = 2'd2;
      end
      c_st: begin
        tuse_rs  = 2'd1;
        tuse_rt  = 2'd2;
      end
      c_br2: begin
        tuse_rs  = 2'd0;
        tuse_rt  = 2'd0;
      end
      c_br1: tuse_rs = 2'd0;
      c_jr:  tuse_rs = 2'd0;
      c_jalr: begin
        tuse_rs  = 2'd0;
        dst_dec  = rd;
      end
      c_jal: dst_dec = 5'd31;
      c_md: begin
        tuse_rs  = 2'd1;
        tuse_rt  = 2'd1;
      end
      c_mf: begin
        dst_dec  = rd;
        tnew_dec = 2'd1;
      end
      c_mt: tuse_rs = 2'd1;
      default: ;
    endcase
  end

  sb_t sb [DEPTH];
  sb_t nxt;
  logic hz;
  logic md_stall;

  // Walk oldest to youngest so the youngest match wins the
  // select; a young match still in flight yields select 0.
  always_comb begin
    hz         = 1'b0;
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb[k].v && (sb[k].dst != 5'd0)) begin
        if (sb[k].dst == rs_d) begin
          if (tuse_rs < sb[k].tnew) hz = 1'b1;
          fwd_rs_sel = (sb[k].tnew == 2'd0)
                     ? FW'(k + 1) : '0;
        end
        if (sb[k].dst == rt_d) begin
          if (tuse_rt < sb[k].tnew) hz = 1'b1;
          fwd_rt_sel = (sb[k].tnew == 2'd0)
                     ? FW'(k + 1) : '0;
        end
      end
    end
  end

  assign stall = hz | md_stall;

  always_comb begin
    nxt = '0;
    if (!stall) begin
      nxt.v    = 1'b1;
      nxt.dst  = dst_dec;
      nxt.tnew = tnew_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[0] <= nxt;
      for (int k = 1; k < DEPTH; k++) begin
        sb[k].v    <= sb[k-1].v;
        sb[k].dst  <= sb[k-1].dst;
        sb[k].tnew <= (sb[k-1].tnew == 2'd0)
                    ? 2'd0 : sb[k-1].tnew - 2'd1;
      end
    end
  end

  assign dst_e  = sb[0].v ? sb[0].dst  : 5'd0;
  assign tnew_e = sb[0].v ? sb[0].tnew : 2'd0;

`ifdef MD_INTERLOCK_EN
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [CW-1:0] cnt;
  logic          md_e;
  logic          div_e;

  // The count is loaded as the op leaves E; md_e covers
  // the op's own E cycle so the unit reads busy at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_e  <= 1'b0;
      div_e <= 1'b0;
      cnt   <= '0;
    end else begin
      md_e  <= c_md && !stall;
      div_e <= fn[1];
      if (md_e)
        cnt <= div_e ? CW'(DIV_CYCLES)
                     : CW'(MULT_CYCLES);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  assign md_busy  = (cnt != '0) || md_e;
  assign md_stall = (c_md | c_mf | c_mt) && md_busy;

  logic unused_ok;
  assign unused_ok = ^instr_d[10:6];
`else
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{instr_d[10:6],
                       c_md, c_mf, c_mt,
                       MULT_CYCLES != 0,
                       DIV_CYCLES != 0};
`endif

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed bench for decode_hazard_unit; expectations follow
// the MD_INTERLOCK_EN setting of the build.
module tb_decode_hazard_unit;

`ifdef MD_INTERLOCK_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        md_busy;
  logic [4:0]  dst_e;
  logic [1:0]  tnew_e;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  decode_hazard_unit dut (
    .clk        (clk),
    .reset      (reset),
    .instr_d    (instr_d),
    .stall      (stall),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy),
    .dst_e      (dst_e),
    .tnew_e     (tnew_e)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i);
    instr_d = i;
    #1;
  endtask

  task automatic flush();
    put(32'h0);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] r_ins(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt);
    return {op, rs, rt, 16'd0};
  endfunction

  localparam logic [5:0] ADDU = 6'b100001;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADIU = 6'b001001;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    instr_d = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_dst_e", dst_e, 0);
    chk("rst_tnew_e", tnew_e, 0);
    chk("rst_fwd_rs", fwd_rs_sel, 0);
    chk("rst_fwd_rt", fwd_rt_sel, 0);

    // lw $1 ; addu $3,$1,$2
    put(i_ins(LW, 5'd0, 5'd1));
    chk("lw_nostall", stall, 0);
    tick();
    chk("lw_dst_e", dst_e, 1);
    chk("lw_tnew_e", tnew_e, 2);
    put(r_ins(5'd1, 5'd2, 5'd3, ADDU));
    chk("rs_d", rs_d, 1);
    chk("rt_d", rt_d, 2);
    chk("lu_stall1", stall, 1);
    tick();
    chk("lu_stall2", stall, 0);
    chk("lu_bubble_dst_e", dst_e, 0);
    tick();
    flush();

    // addu $4 ; beq $4,$0
    put(r_ins(5'd5, 5'd6, 5'd4, ADDU));
    tick();
    put(i_ins(BEQ, 5'd4, 5'd0));
    chk("br_stall1", stall, 1);
    chk("br_fwd_mask", fwd_rs_sel, 0);
    tick();
    chk("br_stall2", stall, 0);
    chk("br_fwd_m", fwd_rs_sel, 2);
    tick();
    flush();

    // lw $4 ; beq $4,$0
    put(i_ins(LW, 5'd0, 5'd4));
    tick();
    put(i_ins(BEQ, 5'd4, 5'd0));
    chk("lbr_stall1", stall, 1);
    tick();
    chk("lbr_stall2", stall, 1);
    tick();
    chk("lbr_stall3", stall, 0);
    chk("lbr_fwd_w", fwd_rs_sel, 3);
    tick();
    flush();

    // jal ; addu $2,$31,$0
    put({6'b000011, 26'd0});
    tick();
    chk("jal_dst_e", dst_e, 31);
    chk("jal_tnew_e", tnew_e, 0);
    put(r_ins(5'd31, 5'd0, 5'd2, ADDU));
    chk("jal_stall", stall, 0);
    chk("jal_fwd_rs", fwd_rs_sel, 1);
    chk("jal_fwd_rt", fwd_rt_sel, 0);
    tick();
    flush();

    // lw $0 ; addu $5,$0,$0
    put(i_ins(LW, 5'd1, 5'd0));
    tick();
    put(r_ins(5'd0, 5'd0, 5'd5, ADDU));
    chk("r0_stall", stall, 0);
    chk("r0_fwd_rs", fwd_rs_sel, 0);
    chk("r0_fwd_rt", fwd_rt_sel, 0);
    tick();
    flush();

    // addu $7 ; sw $7 ; sw $7
    put(r_ins(5'd1, 5'd2, 5'd7, ADDU));
    tick();
    put(i_ins(SW, 5'd0, 5'd7));
    chk("st_stall", stall, 0);
    chk("st_fwd_rt0", fwd_rt_sel, 0);
    tick();
    chk("st_stall2", stall, 0);
    chk("st_fwd_rt_m", fwd_rt_sel, 2);
    tick();
    flush();

    // addiu $8 ; lw $8 ; sw $9,0($8): young lw masks
    put(i_ins(ADIU, 5'd0, 5'd8));
    tick();
    put(i_ins(LW, 5'd0, 5'd8));
    tick();
    put(i_ins(SW, 5'd8, 5'd9));
    chk("mask_stall", stall, 1);
    chk("mask_fwd_rs", fwd_rs_sel, 0);
    chk("mask_md_busy", md_busy, 0);
    tick();
    tick();
    flush();

    // mult $1,$2 ; mflo $3
    put(r_ins(5'd1, 5'd2, 5'd0, 6'b011000));
    chk("mult_stall", stall, 0);
    tick();
    put(r_ins(5'd0, 5'd0, 5'd3, 6'b010010));
    chk("mult_md_busy", md_busy, MD);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      n++;
      tick();
    end
    chk("mflo_stalls", n, MD ? 6 : 0);
    tick();
    flush();

    // div $1,$2 ; mfhi $3
    put(r_ins(5'd1, 5'd2, 5'd0, 6'b011010));
    tick();
    put(r_ins(5'd0, 5'd0, 5'd3, 6'b010000));
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!stall) break;
      n++;
      tick();
    end
    chk("mfhi_stalls", n, MD ? 11 : 0);
    chk("mfhi_md_idle", md_busy, 0);
    tick();
    flush();

    // reset with cnt = 7 and a pending load-use
    put(r_ins(5'd1, 5'd2, 5'd0, 6'b011010));
    tick();
    put(32'h0);
    tick();
    tick();
    tick();
    put(i_ins(LW, 5'd0, 5'd1));
    tick();
    put(r_ins(5'd1, 5'd2, 5'd3, ADDU));
    chk("rm_stall", stall, 1);
    chk("rm_md_busy", md_busy, MD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rm_md_busy0", md_busy, 0);
    chk("rm_dst_e", dst_e, 0);
    chk("rm_tnew_e", tnew_e, 0);
    chk("rm_stall0", stall, 0);
    chk("rm_fwd_rs", fwd_rs_sel, 0);
    tick();
    put(r_ins(5'd0, 5'd0, 5'd3, 6'b010010));
    chk("rm_mflo_stall", stall, 0);
    tick();
    flush();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
